// File: rtl/roll_input_ctrl_pkg.sv
// Shared definitions for the dice roll input controller: FSM encodings,
// default debounce period and the debounce counter width helper.
package roll_input_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT_RB1 = 2'd0,
        WAIT_RB2 = 2'd1,
        LOCKED   = 2'd2
    } roll_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/roll_input_ctrl_btn_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter and a one-cycle
// rise flag raised in the same cycle the debounced level first goes high.
module btn_debounce
    import roll_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          level_reg;
    logic          rise_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 2'b00;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], raw};
            rise_reg <= 1'b0;
            if (sync_reg[1] == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // Accepting a new level; only a 0->1 change counts as a press.
                level_reg <= sync_reg[1];
                rise_reg  <= sync_reg[1];
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/roll_input_ctrl.sv
// Turns two bouncing roll buttons into alternating single-cycle Rb1/Rb2
// requests, counts completed pairs and locks out input once the game ends.
module roll_input_ctrl
    import roll_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [1:0] btn_raw,
    input  logic       Win,
    input  logic       Lose,
    output logic       Rb1,
    output logic       Rb2,
    output logic [1:0] btn_level,
    output logic [3:0] roll_count,
    output logic       locked
);

    logic [1:0]  press;
    roll_state_t state_reg;
    logic        rb1_reg;
    logic        rb2_reg;
    logic        locked_reg;
    logic [3:0]  count_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (CLK),
                .rst_n(reset),
                .raw  (btn_raw[gi]),
                .level(btn_level[gi]),
                .rise (press[gi])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg  <= WAIT_RB1;
            rb1_reg    <= 1'b0;
            rb2_reg    <= 1'b0;
            locked_reg <= 1'b0;
            count_reg  <= 4'd0;
        end else begin
            rb1_reg <= 1'b0;
            rb2_reg <= 1'b0;
            if (Win || Lose) begin
                state_reg  <= LOCKED;
                locked_reg <= 1'b1;
            end else if (!(rb1_reg || rb2_reg)) begin
                // A press arriving right after a pulse is dropped so pulses never abut.
                case (state_reg)
                    WAIT_RB1: begin
                        if (press[0]) begin
                            rb1_reg   <= 1'b1;
                            state_reg <= WAIT_RB2;
                        end
                    end
                    WAIT_RB2: begin
                        if (press[1]) begin
                            rb2_reg   <= 1'b1;
                            state_reg <= WAIT_RB1;
                            if (count_reg != 4'd15) begin
                                count_reg <= count_reg + 4'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign Rb1        = rb1_reg;
    assign Rb2        = rb2_reg;
    assign locked     = locked_reg;
    assign roll_count = count_reg;

endmodule

// File: tb/tb_roll_input_ctrl.sv
// Scoreboard bench for roll_input_ctrl with DEBOUNCE_CYCLES=4: stimulus
// pushes expected pulses (cycle, die), a monitor pops them as pulses appear.
module tb_roll_input_ctrl;
    import roll_input_ctrl_pkg::*;

    localparam int DC  = 4;
    localparam int LAT = DC + 3;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] btn_raw = 2'b00;
    logic       Win = 1'b0;
    logic       Lose = 1'b0;
    logic       Rb1, Rb2, locked;
    logic [1:0] btn_level;
    logic [3:0] roll_count;

    typedef struct packed {
        int cyc;
        int kind;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          last_pulse = -10;
    roll_state_t m_state = WAIT_RB1;
    int          m_count = 0;

    roll_input_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .Win       (Win),
        .Lose      (Lose),
        .Rb1       (Rb1),
        .Rb2       (Rb2),
        .btn_level (btn_level),
        .roll_count(roll_count),
        .locked    (locked)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, req);
        end
    endtask

    task automatic monitor_step();
        exp_t e;
        int   k;
        if (Rb1 || Rb2) begin
            k = Rb1 ? 1 : 2;
            check("both_pulses", int'(Rb1 && Rb2), 0);
            check("back_to_back", int'(last_pulse == cyc - 1), 0);
            last_pulse = cyc;
            if (sb.size() == 0) begin
                check("unexpected_pulse_rb", k, 0);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_die", k, e.kind);
                $display("pulse Rb%0d at cycle %0d (expected Rb%0d at %0d)", k, cyc, e.kind, e.cyc);
            end
        end
    endtask

    // Raise button b now, predict the pulse, hold, then release and settle.
    task automatic press(input int b, input int hold);
        btn_raw[b] = 1'b1;
        if (m_state == WAIT_RB1 && b == 0) begin
            sb.push_back('{cyc: cyc + LAT, kind: 1});
            m_state = WAIT_RB2;
        end else if (m_state == WAIT_RB2 && b == 1) begin
            sb.push_back('{cyc: cyc + LAT, kind: 2});
            m_state = WAIT_RB1;
            if (m_count < 15) m_count++;
        end
        $display("press btn%0d at cycle %0d", b, cyc);
        tick(hold);
        btn_raw[b] = 1'b0;
        tick(9);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_rb1"}, int'(Rb1), 0);
        check({nm, "_rb2"}, int'(Rb2), 0);
        check({nm, "_locked"}, int'(locked), 0);
        check({nm, "_count"}, int'(roll_count), 0);
        check({nm, "_level"}, int'(btn_level), 0);
    endtask

    initial begin
        int c;
        fork
            forever begin
                @(negedge CLK);
                monitor_step();
            end
        join_none

        tick(3);
        check_all_zero("reset");
        reset = 1'b1;
        while (cyc < 10) tick(1);

        // Clean press at cycle 10 -> Rb1 at 17
        btn_raw[0] = 1'b1;
        sb.push_back('{cyc: 17, kind: 1});
        m_state = WAIT_RB2;
        tick(7);
        check("state_after_rb1", int'(dut.state_reg), int'(WAIT_RB2));
        check("level_after_rb1", int'(btn_level), 1);
        tick(2);
        btn_raw[0] = 1'b0;
        tick(9);
        press(1, 9);
        check("count_pair1", int'(roll_count), 1);

        // Button 1 alone in WAIT_RB1 is dropped, button 0 alone in WAIT_RB2 too
        press(1, 9);
        press(0, 9);
        press(0, 9);
        press(1, 9);
        check("count_pair2", int'(roll_count), 2);

        // Bouncing input: no pulse while toggling, one pulse after the final rise
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = ~btn_raw[0];
            tick(2);
        end
        press(0, 9);
        press(1, 9);
        check("count_pair3", int'(roll_count), 3);

        for (int p = 4; p <= 16; p++) begin
            press(0, 9);
            press(1, 9);
            check("count_pair", int'(roll_count), (p > 15) ? 15 : p);
        end

        // Win in the same cycle as a debounced button-1 press
        press(0, 9);
        btn_raw[1] = 1'b1;
        c = cyc;
        tick(6);
        Win = 1'b1;
        tick(1);
        Win = 1'b0;
        m_state = LOCKED;
        check("win_cycle", cyc, c + LAT);
        check("locked_after_win", int'(locked), 1);
        check("rb2_suppressed", int'(Rb2), 0);
        tick(2);
        btn_raw[1] = 1'b0;
        tick(9);
        check("count_after_win", int'(roll_count), 15);
        press(0, 9);
        press(1, 9);
        check("still_locked", int'(locked), 1);

        // Reset mid-debounce with button 0 held
        btn_raw[0] = 1'b1;
        tick(3);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(2);
        check_all_zero("inreset");
        reset = 1'b1;
        m_state = WAIT_RB2;
        m_count = 0;
        sb.push_back('{cyc: cyc + LAT, kind: 1});
        tick(9);
        check("count_after_reset", int'(roll_count), 0);
        check("locked_after_reset", int'(locked), 0);
        check("level_after_reset", int'(btn_level), 1);
        btn_raw[0] = 1'b0;
        tick(9);

        Lose = 1'b1;
        tick(1);
        Lose = 1'b0;
        check("locked_after_lose", int'(locked), 1);
        tick(3);

        check("pending_pulses", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/roll_input_ctrl.md
ROLL_INPUT_CTRL -- requirements
Module: roll_input_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the cycles a synchronized button level must be stable before it is accepted.
REQ-002 CLK  input  1  the single system clock; every flop SHALL be clocked on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 btn_raw  input  2  raw, bouncing pushbuttons; bit 0 is the die-1 roll button and bit 1 is the die-2 roll button.
REQ-005 Win  input  1  game-won status from the dice game.
REQ-006 Lose  input  1  game-lost status from the dice game.
REQ-007 Rb1  output  1  single-cycle request to roll die 1.
REQ-008 Rb2  output  1  single-cycle request to roll die 2.
REQ-009 btn_level  output  2  debounced button levels.
REQ-010 roll_count  output  4  number of completed Rb1-then-Rb2 pairs; saturates at 15.
REQ-011 locked  output  1  high while further requests are blocked.

Function
REQ-012 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-013 Per button, a counter SHALL clear whenever the synchronized level equals btn_level.
- While the levels differ, the counter SHALL increment.
- When the counter reaches DEBOUNCE_CYCLES-1, btn_level SHALL take the synchronized value and the counter SHALL clear.
REQ-014 A press SHALL be a 0->1 transition of btn_level; releases SHALL generate nothing.
REQ-015 Latency from a clean btn_raw rise to the Rb pulse SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-016 The FSM SHALL have three states: WAIT_RB1, WAIT_RB2 and LOCKED.
REQ-017 In WAIT_RB1, a button-0 press SHALL assert Rb1 for exactly one cycle and move the FSM to WAIT_RB2; a button-1 press SHALL be dropped.
REQ-018 In WAIT_RB2, a button-1 press SHALL assert Rb2 for one cycle, increment roll_count (saturating at 15) and return the FSM to WAIT_RB1; a button-0 press SHALL be dropped.
REQ-019 In any state, Win or Lose sampled high SHALL move the FSM to LOCKED on the next edge.
- This transition SHALL take priority over a press in the same cycle, and that press SHALL produce no pulse.
REQ-020 LOCKED SHALL be exited only by reset, and locked SHALL be high exactly while the FSM is in LOCKED.
REQ-021 If both presses occur in the same cycle in WAIT_RB1, only Rb1 SHALL fire; the button-1 press SHALL be discarded and not queued.
REQ-022 Rb1 and Rb2 SHALL never be high in the same cycle, and no two pulses SHALL occur in consecutive cycles.
REQ-023 A button held continuously SHALL generate exactly one press.

Reset
REQ-024 Asserting reset (low) SHALL immediately force:
- FSM to WAIT_RB1;
- Rb1, Rb2 and locked to 0;
- roll_count to 0;
- btn_level, the debounce counters and the synchronizers to 0.
REQ-025 A button already held when reset is released SHALL be seen as a press once it has been debounced.
REQ-026 Reset asserted while a debounce count is in progress SHALL discard that count, with no pulse afterwards.

Structure
REQ-027 A shared package SHALL hold the FSM state encodings (2-bit: WAIT_RB1=0, WAIT_RB2=1, LOCKED=2) and the default DEBOUNCE_CYCLES value.
REQ-028 Synchronizer and debounce logic SHALL live in one sub-module, btn_debounce, instantiated twice and parameterized by DEBOUNCE_CYCLES.
REQ-029 The counter width SHALL be ceil(log2(DEBOUNCE_CYCLES)), with a minimum of 1.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Press btn_raw[0] cleanly at cycle 10 -> Rb1 high only at cycle 17, and the FSM is in WAIT_RB2.
REQ-031 Toggle btn_raw[0] every 2 cycles for 20 cycles, then hold it high -> no pulse during the toggling and exactly one Rb1 pulse 7 cycles after the final rise.
REQ-032 Press button 1 alone in WAIT_RB1, then button 0 -> no Rb2; Rb1 fires only for button 0.
REQ-033 Run 16 complete pairs -> roll_count reads 15 after the 15th and 16th pairs.
REQ-034 Raise Win in the same cycle a debounced button-1 press occurs in WAIT_RB2 -> no Rb2, roll_count unchanged, locked=1; further presses give no pulse until reset.
REQ-035 Pull reset low mid-debounce with btn_raw[0]=1, then release it -> all outputs are 0 during reset, and one Rb1 pulse occurs 7 cycles after release.
